// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. It computes d = a - b - bin one bit per
// clock, LSB first, using a single full-subtractor cell and a borrow
// flip-flop. This trades latency for area: an operation takes WIDTH clock
// cycles of RUN plus one IDLE cycle to accept the next start.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous reset, active-high
//   start  in   1      request a subtraction; sampled only while idle
//   a      in   WIDTH  minuend, captured on the accepted start edge
//   b      in   WIDTH  subtrahend, captured on the accepted start edge
//   bin    in   1      borrow-in, captured on the accepted start edge
//   busy   out  1      high while an operation is in progress
//   done   out  1      one-cycle pulse; d and bout are valid from this cycle
//   d      out  WIDTH  difference, held until the next completion
//   bout   out  1      borrow-out (1 when a < b + bin, unsigned)
//
// {bout, d} is the (WIDTH+1)-bit two's-complement view of a - b - bin.
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    // Bit counter only needs to reach WIDTH-1.
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic             state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] d_q,      d_d;
    logic             bout_q,   bout_d;
    logic             done_q,   done_d;

    // Full-subtractor cell working on the LSBs of the operand shift registers.
    logic a_bit;
    logic b_bit;
    logic diff_bit;
    logic borrow_nxt;
    logic [WIDTH-1:0] res_shifted;

    always_comb begin
        a_bit       = a_q[0];
        b_bit       = b_q[0];
        diff_bit    = a_bit ^ b_bit ^ borrow_q;
        borrow_nxt  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
        // Difference bits enter at the MSB, so after WIDTH shifts bit 0 of
        // the result sits at position 0.
        res_shifted = {diff_bit, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        d_d      = d_q;
        bout_d   = bout_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    count_d  = '0;
                end
            end
            RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = borrow_nxt;
                res_d    = res_shifted;
                count_d  = count_q + CW'(1);
                if (count_q == LAST_BIT) begin
                    // Results update only here, so d/bout stay stable during RUN.
                    state_d = IDLE;
                    d_d     = res_shifted;
                    bout_d  = borrow_nxt;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule
